hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 143 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit. A 32-cycle iterative shift-add multiplier and restoring divider
// share one accumulator. Single-cycle mthi/mtlo writes are also handled here.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrE,
    input  logic [31:0] aluA,
    input  logic [31:0] aluB,
    input  logic        flushE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_hi_q, acc_lo_q, opnd_q;
    logic [31:0] hi_q, lo_q;
    logic        is_div_q, neg_q, rem_neg_q, bzero_q;

    logic        is_special;
    logic [5:0]  funct;
    logic        dec_mult, dec_multu, dec_div, dec_divu, dec_mthi, dec_mtlo;
    logic        dec_start, start;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        unused_instr;

    assign is_special   = (instrE[31:26] == 6'b000000);
    assign funct        = instrE[5:0];
    assign unused_instr = ^instrE[25:6];

    assign dec_mult  = is_special && (funct == 6'b011000);
    assign dec_multu = is_special && (funct == 6'b011001);
    assign dec_div   = is_special && (funct == 6'b011010);
    assign dec_divu  = is_special && (funct == 6'b011011);
    assign dec_mthi  = is_special && (funct == 6'b010001);
    assign dec_mtlo  = is_special && (funct == 6'b010011);
    assign dec_start = dec_mult | dec_multu | dec_div | dec_divu;
    assign start     = (state_q == StIdle) && dec_start && !flushE;

    assign a_neg = (dec_mult | dec_div) & aluA[31];
    assign b_neg = (dec_mult | dec_div) & aluB[31];
    assign a_mag = a_neg ? (32'd0 - aluA) : aluA;
    assign b_mag = b_neg ? (32'd0 - aluB) : aluB;

    // One iteration of the shared datapath, computed from the current accumulator.
    logic [32:0] add_sum, shifted, diff;
    logic [31:0] nxt_hi, nxt_lo;

    always_comb begin
        add_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        shifted = {acc_hi_q, acc_lo_q[31]};
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!diff[32]) begin
                nxt_hi = diff[31:0];
                nxt_lo = {acc_lo_q[30:0], 1'b1};
            end else begin
                nxt_hi = shifted[31:0];
                nxt_lo = {acc_lo_q[30:0], 1'b0};
            end
        end else begin
            nxt_hi = add_sum[32:1];
            nxt_lo = {add_sum[0], acc_lo_q[31:1]};
        end
    end

    // Sign correction of the final iteration's result.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_q ? (64'd0 - {nxt_hi, nxt_lo}) : {nxt_hi, nxt_lo};
        quo_fix  = bzero_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - nxt_lo) : nxt_lo);
        rem_fix  = rem_neg_q ? (32'd0 - nxt_hi) : nxt_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            opnd_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StRun;
                        cnt_q     <= 5'd31;
                        acc_hi_q  <= 32'd0;
                        is_div_q  <= dec_div | dec_divu;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        bzero_q   <= (aluB == 32'd0);
                        if (dec_div | dec_divu) begin
                            acc_lo_q <= a_mag;
                            opnd_q   <= b_mag;
                        end else begin
                            acc_lo_q <= b_mag;
                            opnd_q   <= a_mag;
                        end
                    end else if (!flushE) begin
                        if (dec_mthi) hi_q <= aluA;
                        if (dec_mtlo) lo_q <= aluA;
                    end
                end
                StRun: begin
                    acc_hi_q <= nxt_hi;
                    acc_lo_q <= nxt_lo;
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= StDone;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // busy rises in the start cycle itself so the hazard unit stalls immediately.
    assign busy = !rst && ((state_q == StRun) || start);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected {HI,LO} pushed at start, popped in the DONE cycle.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrE, aluA, aluB;
    logic        flushE;
    logic [31:0] HI, LO;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_hi, exp_lo;

    localparam logic [5:0] FnMult = 6'h18, FnMultu = 6'h19, FnDiv = 6'h1a, FnDivu = 6'h1b;
    localparam logic [5:0] FnMthi = 6'h11, FnMtlo = 6'h13, FnMflo = 6'h12;

    hilo_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .instrE (instrE),
        .aluA   (aluA),
        .aluB   (aluB),
        .flushE (flushE),
        .HI     (HI),
        .LO     (LO),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        int sq, sr;
        case (fn)
            FnMult:  return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            FnMultu: return {32'd0, a} * {32'd0, b};
            FnDiv: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drives one operation, holds it while busy, then retires it to mflo in the DONE cycle.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit flush_mid);
        int nb;
        logic [63:0] e;
        instrE = {26'd0, fn};
        aluA   = a;
        aluB   = b;
        exp_q.push_back(exp);
        #1;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            flushE = flush_mid && (nb >= 5 && nb <= 7);
            @(negedge clk);
            #1;
        end
        flushE = 1'b0;
        check_eq({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_hi"}, {32'd0, HI}, {32'd0, e[63:32]});
            check_eq({tag, "_lo"}, {32'd0, LO}, {32'd0, e[31:0]});
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
        instrE = {26'd0, FnMflo};
        @(negedge clk);
        #1;
        check_eq({tag, "_no_restart"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_hold"}, {HI, LO}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [5:0]  fn;
        logic [31:0] ra, rb;
        rst    = 1'b1;
        instrE = 32'd0;
        aluA   = 32'd0;
        aluB   = 32'd0;
        flushE = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_hi", {32'd0, HI}, 64'd0);
        check_eq("reset_lo", {32'd0, LO}, 64'd0);
        check_eq("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_op("mult_neg", FnMult, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("multu", FnMultu, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0);
        run_op("div_neg", FnDiv, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divu", FnDivu, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        run_op("divu_zero", FnDivu, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 1'b0);
        run_op("div_ovf", FnDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op("div_zero_neg", FnDiv, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
        run_op("mult_flush_mid", FnMult, 32'd12345, 32'hFFFF_FF00,
               model(FnMult, 32'd12345, 32'hFFFF_FF00), 1'b1);

        for (int i = 0; i < 6; i++) begin
            fn = 6'(FnMult + 6'($urandom_range(0, 3)));
            ra = $urandom;
            rb = (i == 2) ? 32'(16'($urandom)) : $urandom;
            run_op("rand", fn, ra, rb, model(fn, ra, rb), 1'b0);
        end

        // mthi / mtlo: single-cycle write, never stalls.
        instrE = {26'd0, FnMthi};
        aluA   = 32'hA5A5_A5A5;
        #1;
        check_eq("mthi_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        #1;
        check_eq("mthi_hi", {32'd0, HI}, 64'h0000_0000_A5A5_A5A5);
        check_eq("mthi_lo", {32'd0, LO}, {32'd0, exp_lo});
        exp_hi = 32'hA5A5_A5A5;
        instrE = {26'd0, FnMtlo};
        aluA   = 32'h5A5A_0F0F;
        @(negedge clk);
        #1;
        check_eq("mtlo_lo", {32'd0, LO}, 64'h0000_0000_5A5A_0F0F);
        check_eq("mtlo_hi", {32'd0, HI}, {32'd0, exp_hi});
        exp_lo = 32'h5A5A_0F0F;

        // Flushed start must not begin an operation.
        instrE = {26'd0, FnMult};
        aluA   = 32'd7;
        aluB   = 32'd9;
        flushE = 1'b1;
        #1;
        check_eq("flush_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        flushE = 1'b0;
        instrE = 32'd0;
        #1;
        check_eq("flush_no_run", {63'd0, busy}, 64'd0);
        check_eq("flush_hold", {HI, LO}, {exp_hi, exp_lo});

        // Reset in the middle of a divide.
        instrE = {26'd0, FnDiv};
        aluA   = 32'd1000;
        aluB   = 32'd3;
        @(negedge clk);
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_hi", {32'd0, HI}, 64'd0);
        check_eq("rst_mid_lo", {32'd0, LO}, 64'd0);
        check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_op("multu_after_rst", FnMultu, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
